// File: rtl/spi_master.sv
// spi_master: byte-oriented SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first,
// active-low slave select), paced entirely from i_clk.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | link idle, o_ssel=1, o_ready=1, o_mosi=0
// SETUP  | o_ssel=0, o_sck=0, first bit presented on o_mosi
// HIGH   | o_sck=1; miso sampled on the final cycle
// LOW    | o_sck=0; next bit already on o_mosi
// LINGER | between burst bytes, o_ssel=0, o_ready=1, o_mosi held
// HOLD   | o_ssel still 0 after the final byte
// GAP    | o_ssel=1, o_ready=0, guard time before IDLE
//
// Parameters:
//   CLK_DIV     o_sck half-period in i_clk cycles (legal 2..255)
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     transfer request, honoured only while o_ready=1
//   i_tx_data   byte to send, captured on acceptance
//   i_last      1 = release o_ssel after this byte, 0 = keep it low
//   o_ready     a start is accepted this cycle
//   o_byte_done one-cycle pulse, o_rx_data valid from this cycle
//   o_rx_data   last received byte, held until the next o_byte_done
//   o_sck       SPI clock, idle low
//   o_mosi      SPI data out
//   i_miso      SPI data in, treated as synchronous to i_clk
//   o_ssel      slave select, active low

module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_byte_done,
  output logic [7:0] o_rx_data,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_ssel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LINGER,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_div;
  // Bit 7 goes straight from i_tx_data to o_mosi on acceptance, so only
  // the remaining seven bits need to be kept for shifting.
  logic [6:0] r_tx_shift;
  // The eighth received bit is taken directly from i_miso when the byte
  // completes, so seven bits of history are enough.
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic       r_last;

  logic       w_div_done;
  logic       w_accept;

  assign w_div_done = (r_div == 8'd0);
  // o_ready is only ever 1 in IDLE or LINGER.
  assign w_accept   = i_start && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_div       <= DIV_RELOAD;
      r_tx_shift  <= 7'd0;
      r_rx_shift  <= 7'd0;
      r_bit_cnt   <= 3'd0;
      r_last      <= 1'b0;
      o_ready     <= 1'b1;
      o_byte_done <= 1'b0;
      o_rx_data   <= 8'h00;
      o_sck       <= 1'b0;
      o_mosi      <= 1'b0;
      o_ssel      <= 1'b1;
    end else begin
      o_byte_done <= 1'b0;
      // Free-running down-count; every state transition below reloads it.
      if (!w_div_done) begin
        r_div <= r_div - 8'd1;
      end

      case (r_state)
        S_IDLE, S_LINGER: begin
          if (w_accept) begin
            r_tx_shift <= i_tx_data[6:0];
            r_last     <= i_last;
            r_bit_cnt  <= 3'd0;
            r_state    <= S_SETUP;
            r_div      <= DIV_RELOAD;
            o_ssel     <= 1'b0;
            o_sck      <= 1'b0;
            o_mosi     <= i_tx_data[7];
            o_ready    <= 1'b0;
          end
        end

        S_SETUP: begin
          if (w_div_done) begin
            r_state <= S_HIGH;
            r_div   <= DIV_RELOAD;
            o_sck   <= 1'b1;
          end
        end

        S_HIGH: begin
          if (w_div_done) begin
            r_rx_shift <= {r_rx_shift[5:0], i_miso};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_div      <= DIV_RELOAD;
            o_sck      <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              // Eighth bit: no trailing LOW phase, and o_mosi keeps bit 0.
              o_byte_done <= 1'b1;
              o_rx_data   <= {r_rx_shift, i_miso};
              if (r_last) begin
                r_state <= S_HOLD;
              end else begin
                r_state <= S_LINGER;
                o_ready <= 1'b1;
              end
            end else begin
              r_state    <= S_LOW;
              r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              o_mosi     <= r_tx_shift[6];
            end
          end
        end

        S_LOW: begin
          if (w_div_done) begin
            r_state <= S_HIGH;
            r_div   <= DIV_RELOAD;
            o_sck   <= 1'b1;
          end
        end

        S_HOLD: begin
          if (w_div_done) begin
            r_state <= S_GAP;
            r_div   <= DIV_RELOAD;
            o_ssel  <= 1'b1;
          end
        end

        S_GAP: begin
          if (w_div_done) begin
            r_state <= S_IDLE;
            r_div   <= DIV_RELOAD;
            o_ready <= 1'b1;
            o_mosi  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_div   <= DIV_RELOAD;
          o_ready <= 1'b1;
          o_sck   <= 1'b0;
          o_mosi  <= 1'b0;
          o_ssel  <= 1'b1;
        end
      endcase
    end
  end

endmodule
